// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEG_ID,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_SHIFT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SYNC  = 2'd1;
    localparam logic [1:0] ERR_ZLEN  = 2'd2;
    localparam logic [1:0] ERR_SEGID = 2'd3;

    localparam logic [7:0] END_ID        = 8'hFF;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Every state between leaving IDLE/DONE/ERR and returning to one of them.
    function automatic logic is_loading(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Byte buffer and bit counters that turn accepted data bytes into an MSB-first
// bit stream, one bit per clock, truncating the final partial byte.
module cfg_serializer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             len_load,
    input  logic [LEN_W-1:0] len,
    input  logic             take,
    input  logic [7:0]       data,
    output logic             cfg_bit,
    output logic             shift_next,
    output logic             last,
    output logic             ready
);

    logic [7:0]       buf_q;
    logic [2:0]       cnt;      // bits still to emit after the one on cfg_bit
    logic [LEN_W-1:0] rem;      // segment bits not yet loaded into the buffer
    logic             strobe;
    logic [3:0]       take_n;

    assign take_n     = (rem >= LEN_W'(8)) ? 4'd8 : rem[3:0];
    assign shift_next = take || (cnt != 3'd0);
    assign last       = strobe && (cnt == 3'd0) && (rem == '0);
    // A new byte is wanted only once the buffer is on its final bit.
    assign ready      = (cnt == 3'd0) && (rem != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q   <= 8'd0;
            cnt     <= 3'd0;
            rem     <= '0;
            strobe  <= 1'b0;
            cfg_bit <= 1'b0;
        end else if (len_load) begin
            rem    <= len;
            cnt    <= 3'd0;
            strobe <= 1'b0;
        end else if (take) begin
            cfg_bit <= data[7];
            buf_q   <= {data[6:0], 1'b0};
            cnt     <= 3'(take_n - 4'd1);
            rem     <= rem - LEN_W'(take_n);
            strobe  <= 1'b1;
        end else if (cnt != 3'd0) begin
            cfg_bit <= buf_q[7];
            buf_q   <= {buf_q[6:0], 1'b0};
            cnt     <= cnt - 3'd1;
            strobe  <= 1'b1;
        end else begin
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Configuration sequencer: parses sync/segment headers from the host byte
// stream and shifts each segment into its configuration chain.
module cfg_bitstream_loader
    import cfg_loader_pkg::*;
#(
    parameter int         NUM_SEG   = 4,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         LEN_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               prgm_b,
    output logic               cfg_bit,
    output logic [NUM_SEG-1:0] cfg_shift,
    output logic [NUM_SEG-1:0] seg_loaded,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    state_t             state, state_d;
    logic [7:0]         seg_id;
    logic [7:0]         len_hi;
    logic [1:0]         err_d;
    logic [LEN_W-1:0]   len_full;
    logic [NUM_SEG-1:0] seg_onehot;
    logic               hs, start_ok, len_load, ser_take;
    logic               shift_next, ser_last, ser_ready;

    assign hs       = s_valid && s_ready;
    assign start_ok = start && !is_loading(state);
    assign len_full = LEN_W'({len_hi, s_data});
    assign len_load = hs && (state == ST_LEN_LO) && (len_full != '0);
    assign ser_take = hs && (state == ST_SHIFT);

    cfg_serializer #(.LEN_W(LEN_W)) u_ser (
        .clk        (clk),
        .reset      (reset),
        .len_load   (len_load),
        .len        (len_full),
        .take       (ser_take),
        .data       (s_data),
        .cfg_bit    (cfg_bit),
        .shift_next (shift_next),
        .last       (ser_last),
        .ready      (ser_ready)
    );

    always_comb begin
        seg_onehot = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            seg_onehot[i] = (seg_id == 8'(i));
        end
    end

    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_SYNC, ST_SEG_ID, ST_LEN_HI, ST_LEN_LO: s_ready = 1'b1;
            ST_SHIFT:                                 s_ready = ser_ready;
            default:                                  s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        err_d   = ERR_NONE;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (hs) begin
                    if (s_data == SYNC_BYTE) begin
                        state_d = ST_SEG_ID;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_SYNC;
                    end
                end
            end
            ST_SEG_ID: begin
                if (hs) begin
                    if (s_data == END_ID) begin
                        state_d = ST_DONE;
                    end else if (32'(s_data) < NUM_SEG) begin
                        state_d = ST_LEN_HI;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_SEGID;
                    end
                end
            end
            ST_LEN_HI: begin
                if (hs) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (hs) begin
                    if (len_full == '0) begin
                        state_d = ST_ERR;
                        err_d   = ERR_ZLEN;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (ser_last) state_d = ST_SEG_ID;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            seg_id     <= 8'd0;
            len_hi     <= 8'd0;
            cfg_shift  <= '0;
            seg_loaded <= '0;
            busy       <= 1'b0;
            prgm_b     <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state     <= state_d;
            busy      <= is_loading(state_d);
            prgm_b    <= !is_loading(state_d);
            cfg_shift <= shift_next ? seg_onehot : '0;
            if (hs && (state == ST_SEG_ID)) seg_id <= s_data;
            if (hs && (state == ST_LEN_HI)) len_hi <= s_data;
            if (start_ok) begin
                seg_loaded <= '0;
                done       <= 1'b0;
                error      <= 1'b0;
                err_code   <= ERR_NONE;
            end else begin
                if ((state == ST_SHIFT) && ser_last) seg_loaded <= seg_loaded | seg_onehot;
                if ((state == ST_SEG_ID) && (state_d == ST_DONE)) done <= 1'b1;
                if ((state != ST_ERR) && (state_d == ST_ERR)) begin
                    error    <= 1'b1;
                    err_code <= err_d;
                end
            end
        end
    end

endmodule

// File: doc/cfg_bitstream_loader.md
# cfg_bitstream_loader

Top-level configuration sequencer for the emulator fabric. It accepts a byte-wide bitstream from the host link through a valid/ready handshake and validates a sync byte and per-segment headers. It then serialises each segment MSB-first into the addressed configuration shift chain: IO select chain, CLB chain, switch-box chain and so on. It owns `prgm_b` for the whole fabric. It reports completion, per-segment load status and error codes to the host.

## Interface
Parameters:
- `NUM_SEG`, 4, number of configuration shift chains driven (segment IDs 0..NUM_SEG-1)
- `SYNC_BYTE`, 8'hA5, required first byte of every bitstream
- `LEN_W`, 16, width of the segment bit-length field

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only
- `s_valid`  in  1  host byte valid
- `s_data`  in  8  host byte
- `s_ready`  out  1  loader accepts byte; transfer occurs when `s_valid && s_ready`
- `prgm_b`  out  1  fabric program enable, active-low; 0 while loading
- `cfg_bit`  out  1  serial configuration data, shared by all chains
- `cfg_shift`  out  NUM_SEG  one-hot shift enable per chain; all-zero means hold
- `seg_loaded`  out  NUM_SEG  sticky, set when a segment's last bit has been shifted
- `busy`  out  1  high in every state except IDLE, DONE and ERR
- `done`  out  1  sticky, set when the end marker is received
- `error`  out  1  sticky, set on a protocol error
- `err_code`  out  2  1 = bad sync, 2 = zero length, 3 = bad segment ID; 0 otherwise

## Operation
- Stream format: `SYNC_BYTE`, then repeated {seg_id, len_hi, len_lo, ceil(len/8) data bytes}, terminated by seg_id 8'hFF. The end marker carries no length field.
- FSM states: IDLE, SYNC, SEG_ID, LEN_HI, LEN_LO, SHIFT, DONE, ERR.
- IDLE/DONE/ERR + `start`: clear `done`, `error`, `err_code` and `seg_loaded`; go to SYNC.
- SYNC: accept 1 byte. If it equals `SYNC_BYTE`, go to SEG_ID. Otherwise go to ERR with code 1.
- SEG_ID: accept 1 byte.
  - 8'hFF: go to DONE.
  - Value < NUM_SEG: latch it and go to LEN_HI.
  - Any other value: go to ERR with code 3.
- LEN_HI / LEN_LO: accept 1 byte each, giving the big-endian bit count L. If L == 0, go to ERR with code 2. Otherwise go to SHIFT.
- SHIFT: emit exactly L bits, MSB-first within each byte.
  - If L mod 8 != 0, only the upper L mod 8 bits of the final byte are emitted; the rest are discarded.
  - After the last bit, set `seg_loaded[id]` and return to SEG_ID.
- A segment ID may repeat. The chain is shifted again and `seg_loaded` stays set.
- `prgm_b` = 0 in states SYNC..SHIFT, and 1 otherwise.
- `s_ready` = 0 in IDLE, DONE and ERR; extra host bytes in these states are not consumed.

## Timing
- Reset values: `prgm_b`=1, `cfg_shift`=0, `cfg_bit`=0, `s_ready`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `seg_loaded`=0. The FSM enters IDLE.
- All outputs are registered except `s_ready`, which is combinational from state and buffer count.
- `start` at cycle t: `busy`=1 and `prgm_b`=0 at t+1, and `s_ready`=1 at t+1.
- Header bytes: one byte per accepted handshake; the state advances on the cycle after the handshake.
- Data byte accepted at cycle t: its first bit appears on `cfg_bit`, with `cfg_shift[id]` high, during t+1. Its eighth bit appears during t+8.
- In SHIFT, `s_ready` = (buffered bits ≤ 1) && (unbuffered segment bits > 0). With the host continuously valid, this gives gapless output at 1 bit per clk.
- Host stall: `cfg_shift` drops to 0 for each bubble cycle, and `cfg_bit` holds its last value. The chains must not shift on bubble cycles.
- `seg_loaded[id]` sets on the cycle after the last `cfg_shift[id]` pulse. That is also the first cycle of SEG_ID.
- `done` and `prgm_b`=1 go high on the cycle after the end-marker handshake.
- ERR: `error`, `err_code` and `prgm_b`=1 all go high on the cycle after the offending byte. `cfg_shift` is forced to 0 at the same time.
- Reset mid-load: the FSM goes to IDLE immediately. The chains are left partially loaded, and `seg_loaded` is cleared.
- `start` while busy: ignored.

## Structure
- Package `cfg_loader_pkg`:
  - state enum
  - error-code constants (`ERR_NONE`, `ERR_SYNC`, `ERR_ZLEN`, `ERR_SEGID`)
  - `END_ID` = 8'hFF
  - default `SYNC_BYTE`
- Sub-module `cfg_serializer` contains the 8-bit byte buffer, buffered-bit counter and remaining-bit down-counter (`LEN_W`). It produces `cfg_bit`, the shift strobe and the last-bit flag, and computes the SHIFT-state term of `s_ready`.
- The top level holds the FSM, header capture, one-hot decode of `cfg_shift`, and the status registers.

## Test plan
- Stream A5, 00, 00, 10, 8'hC3, 8'h5A, FF with the host always valid → 16 consecutive `cfg_shift[0]` cycles carrying bits 1100001101011010; `seg_loaded`=4'b0001; `done`=1; `prgm_b` returns to 1.
- Stream A5, 02, 00, 05, 8'hF8, FF → 5 bits 11111 on `cfg_shift[2]`; the low 3 bits are discarded; `seg_loaded`=4'b0100.
- Stream A5, 01, 00, 10, 8'hFF, 8'h00 with `s_valid` low for 3 cycles between the data bytes → 3 bubble cycles with `cfg_shift`=0, then the remaining 8 bits.
- Error cases, each checking `error` and `err_code`:
  - first byte 8'h3C → ERR, code 1
  - A5, 07 → ERR, code 3
  - A5, 00, 00, 00 → ERR, code 2
  - In every case, `cfg_shift` never pulses and `s_ready`=0 afterwards.
- Reset asserted after the 4th shifted bit of a 16-bit segment → all outputs at reset values next cycle. A following `start` with a full valid stream loads correctly.
- Four segments 0..3, each 8 bits, sent back-to-back → `seg_loaded`=4'b1111 and 32 gapless shift cycles overall (excluding header cycles); `start` pulsed mid-load is ignored.
